// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered
// sync, data-enable, pixel coordinate and line/frame strobe decodes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS_C   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS_C   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);

  logic [CW-1:0] hcnt_reg, hcnt_next;
  logic [CW-1:0] vcnt_reg, vcnt_next;

  logic          hsync_reg, vsync_reg, de_reg, line_start_reg, frame_start_reg;
  logic [CW-1:0] x_reg, y_reg;

  logic          hsync_next, vsync_next, de_next, line_start_next, frame_start_next;
  logic [CW-1:0] x_next, y_next;

  // Counter advance; vcnt only moves on the hcnt wrap.
  always_comb begin
    hcnt_next = hcnt_reg + 1'b1;
    vcnt_next = vcnt_reg;
    if (hcnt_reg == H_LAST_C) begin
      hcnt_next = '0;
      vcnt_next = (vcnt_reg == V_LAST_C) ? '0 : vcnt_reg + 1'b1;
    end
  end

  // Decode of the current counters; registered below for one ce-cycle latency.
  always_comb begin
    de_next          = (hcnt_reg < H_ACT_C) && (vcnt_reg < V_ACT_C);
    hsync_next       = ((hcnt_reg >= H_SS_C) && (hcnt_reg < H_SE_C)) ? H_POL : ~H_POL;
    vsync_next       = ((vcnt_reg >= V_SS_C) && (vcnt_reg < V_SE_C)) ? V_POL : ~V_POL;
    x_next           = de_next ? hcnt_reg : '0;
    y_next           = de_next ? vcnt_reg : '0;
    line_start_next  = (hcnt_reg == '0);
    frame_start_next = (hcnt_reg == '0) && (vcnt_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      de_reg          <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (ce) begin
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= de_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry instance checked cycle by cycle
// against a scoreboard, plus a default 640x480 instance checked on line timing.
module tb_vga_timing_gen;

  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ce;
  logic          hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  logic       rst_d;
  logic       hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
  logic [9:0] x_d, y_d;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .ce(1'b1),
    .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(line_start_d), .frame_start(frame_start_d)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state and scoreboard of expected output vectors
  // {hsync, vsync, de, x, y, line_start, frame_start}.
  int          m_h = 0;
  int          m_v = 0;
  logic [14:0] e_vec = 15'h0;
  logic [14:0] sb[$];
  int          txn = 0;

  task automatic drive(input logic r, input logic c, input string tag);
    logic        de_e, hs_e, vs_e;
    logic [4:0]  x_e, y_e;
    logic [14:0] exp_v, got_v;
    rst = r;
    ce  = c;
    if (r) begin
      m_h   = 0;
      m_v   = 0;
      e_vec = {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    end else if (c) begin
      de_e  = (m_h < 8) && (m_v < 4);
      hs_e  = !((m_h >= 10) && (m_h < 13));
      vs_e  = !((m_v >= 5) && (m_v < 7));
      x_e   = de_e ? 5'(m_h) : 5'd0;
      y_e   = de_e ? 5'(m_v) : 5'd0;
      e_vec = {hs_e, vs_e, de_e, x_e, y_e, (m_h == 0), (m_h == 0) && (m_v == 0)};
      if (m_h == 15) begin
        m_h = 0;
        m_v = (m_v == 7) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    sb.push_back(e_vec);
    @(posedge clk);
    #1;
    got_v = {hsync, vsync, de, x, y, line_start, frame_start};
    txn++;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_v = sb.pop_front();
      check(tag, 32'(got_v), 32'(exp_v));
      $display("txn %0d %s rst=%0b ce=%0b out=%04h exp=%04h", txn, tag, r, c, got_v, exp_v);
    end
    @(negedge clk);
  endtask

  int fs_rise0, fs_rise1, fs_width;
  logic fs_prev;
  int ls0, ls1, hs_fall, hs_rise, de_cnt;
  logic hs_prev;

  initial begin
    rst   = 1'b1;
    ce    = 1'b0;
    rst_d = 1'b1;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, "reset");
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_de", 32'(de), 32'd0);

    // Horizontal / vertical raster with ce tied high
    for (int i = 1; i <= 140; i++) begin
      drive(1'b0, 1'b1, "raster");
      if (i == 1) begin
        check("c1_frame_start", 32'(frame_start), 32'd1);
        check("c1_line_start", 32'(line_start), 32'd1);
        check("c1_de", 32'(de), 32'd1);
        check("c1_sync", 32'({hsync, vsync}), 32'd3);
      end
      if (i == 2) check("c2_x_fs", 32'({x, frame_start}), 32'({5'd1, 1'b0}));
      if (i == 8) check("c8_x", 32'(x), 32'd7);
      if (i == 9) check("c9_de", 32'(de), 32'd0);
      if (i == 11) check("c11_hsync", 32'(hsync), 32'd0);
      if (i == 14) check("c14_hsync", 32'(hsync), 32'd1);
      if (i == 17) check("c17_ls_y_x", 32'({line_start, y, x}), 32'({1'b1, 5'd1, 5'd0}));
      if (i == 81) check("c81_vsync", 32'(vsync), 32'd0);
      if (i == 113) check("c113_vsync", 32'(vsync), 32'd1);
      if (i == 129) check("c129_frame_start", 32'(frame_start), 32'd1);
    end

    // ce toggling: frame period doubles, pulses last two clocks
    drive(1'b1, 1'b1, "ce_rst");
    fs_rise0 = -1; fs_rise1 = -1; fs_width = 0; fs_prev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive(1'b0, (i % 2) == 0, "ce_toggle");
      if (frame_start && !fs_prev) begin
        if (fs_rise0 < 0) fs_rise0 = i;
        else if (fs_rise1 < 0) fs_rise1 = i;
      end
      if (frame_start && fs_rise1 < 0) fs_width++;
      fs_prev = frame_start;
    end
    check("ce_frame_period", 32'(fs_rise1 - fs_rise0), 32'd256);
    check("ce_fs_width", 32'(fs_width), 32'd2);

    // Reset during vsync
    drive(1'b1, 1'b1, "mid_rst_pre");
    for (int i = 0; i < 83; i++) drive(1'b0, 1'b1, "to_vsync");
    check("in_vsync", 32'(vsync), 32'd0);
    drive(1'b1, 1'b1, "mid_rst");
    check("mid_rst_out", 32'({vsync, hsync, de, x, y}), 32'({1'b1, 1'b1, 1'b0, 5'd0, 5'd0}));
    drive(1'b0, 1'b1, "restart");
    check("restart_fs", 32'(frame_start), 32'd1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, "after_rst");

    // Default 640x480 geometry: line timing
    rst_d = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    ls0 = -1; ls1 = -1; hs_fall = -1; hs_rise = -1; de_cnt = 0; hs_prev = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      @(posedge clk);
      #1;
      if (line_start_d) begin
        if (ls0 < 0) ls0 = c;
        else if (ls1 < 0) ls1 = c;
      end
      if (c <= 800 && de_d) de_cnt++;
      if (!hsync_d && hs_prev && hs_fall < 0) hs_fall = c;
      if (hsync_d && !hs_prev && hs_rise < 0) hs_rise = c;
      hs_prev = hsync_d;
    end
    $display("txn default_geometry ls0=%0d ls1=%0d hs_fall=%0d hs_rise=%0d de_cnt=%0d",
             ls0, ls1, hs_fall, hs_rise, de_cnt);
    check("d_first_line_start", 32'(ls0), 32'd1);
    check("d_line_period", 32'(ls1 - ls0), 32'd800);
    check("d_hsync_fall", 32'(hs_fall), 32'd657);
    check("d_hsync_rise", 32'(hs_rise), 32'd753);
    check("d_de_count", 32'(de_cnt), 32'd640);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
